// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: steps a 3-input gate through all eight input rows, holds each
// row for SETTLE_CYCLES clocks, samples the gate output and compares the
// captured truth table against EXPECTED.
module tt_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [7:0]  EXPECTED      = 8'h8B
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] captured,
    output logic [3:0] fail_cnt,
    output logic [2:0] first_fail
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] row_q, row_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] captured_q, captured_d;
    logic [3:0] fail_cnt_q, fail_cnt_d;
    logic [2:0] first_fail_q, first_fail_d;
    logic       pass_q, pass_d;
    logic       mismatch;

    // State and result registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            row_q        <= '0;
            cnt_q        <= '0;
            captured_q   <= '0;
            fail_cnt_q   <= '0;
            first_fail_q <= '0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            cnt_q        <= cnt_d;
            captured_q   <= captured_d;
            fail_cnt_q   <= fail_cnt_d;
            first_fail_q <= first_fail_d;
            pass_q       <= pass_d;
        end
    end

    // Next-state: sweep sequencing, row capture and mismatch bookkeeping
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        cnt_d        = cnt_q;
        captured_d   = captured_q;
        fail_cnt_d   = fail_cnt_q;
        first_fail_d = first_fail_q;
        pass_d       = pass_q;
        mismatch     = 1'b0;

        case (state_q)
            IDLE: begin
                // abort has priority over start so a simultaneous request is dropped
                if (start && !abort) begin
                    state_d      = APPLY;
                    row_d        = '0;
                    cnt_d        = RELOAD;
                    captured_d   = '0;
                    fail_cnt_d   = '0;
                    first_fail_d = '0;
                    pass_d       = 1'b0;
                end
            end
            APPLY: begin
                if (abort) begin
                    // partial results are kept; only pass is forced low
                    state_d = IDLE;
                    row_d   = '0;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    captured_d[3'd7 - row_q] = dut_out;
                    mismatch = (dut_out != EXPECTED[3'd7 - row_q]);
                    if (mismatch) begin
                        // at most eight rows are visited, so this never exceeds 8
                        fail_cnt_d = fail_cnt_q + 4'd1;
                        if (fail_cnt_q == 4'd0) begin
                            first_fail_d = row_q;
                        end
                    end
                    if (row_q != 3'd7) begin
                        row_d = row_q + 3'd1;
                        cnt_d = RELOAD;
                    end else begin
                        state_d = DONE;
                        row_d   = '0;
                        pass_d  = (fail_cnt_d == 4'd0);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (abort) begin
                    pass_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: gate inputs are only driven while a row is applied
    always_comb begin
        {in1, in2, in3} = (state_q == APPLY) ? row_q : 3'b000;
        busy            = (state_q == APPLY);
        done            = (state_q == DONE);
        pass            = pass_q;
        captured        = captured_q;
        fail_cnt        = fail_cnt_q;
        first_fail      = first_fail_q;
    end

endmodule

// File: doc/tt_sweep_ctrl.md
TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, clocks each input row is held before the output is sampled; legal range 1..255.
REQ-002 Parameter EXPECTED, default 8'h8B, golden 3-input truth table; row r={in1,in2,in3} expects EXPECTED[7-r].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 start  input  1  request one full truth-table sweep; sampled only in IDLE.
REQ-006 abort  input  1  cancel a sweep in progress.
REQ-007 dut_out  input  1  output of the logic gate under control.
REQ-008 in1, in2, in3  output  1 each  drive the gate inputs; in1 is MSB of the row index.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse when a sweep completes normally.
REQ-011 pass  output  1  captured table equals EXPECTED; valid from done until next start.
REQ-012 captured  output  8  observed table, same bit ordering as EXPECTED.
REQ-013 fail_cnt  output  4  number of mismatching rows, 0..8.
REQ-014 first_fail  output  3  lowest mismatching row index; 0 when fail_cnt=0.

Function
REQ-015 FSM states SHALL be IDLE, APPLY, DONE.
REQ-016 IDLE: in1..in3=0, busy=0; start=1 and abort=0 -> APPLY with row=0, settle counter=SETTLE_CYCLES-1, and captured, fail_cnt, first_fail, pass cleared.
REQ-017 APPLY: {in1,in2,in3}=row, busy=1; row held constant for exactly SETTLE_CYCLES clocks.
REQ-018 APPLY, counter>0: counter decrements each clock.
REQ-019 APPLY, counter=0: at that edge dut_out is written to captured[7-row].
REQ-020 At the same edge, a mismatch with EXPECTED[7-row] increments fail_cnt; if it is the first mismatch, first_fail is set to row.
REQ-021 At the same edge, if row<7: row increments, counter reloads SETTLE_CYCLES-1; if row=7: -> DONE.
REQ-022 Row index SHALL NOT wrap within a sweep; rows visited 0..7 strictly in order, each exactly once.
REQ-023 Sweep latency: busy high exactly 8*SETTLE_CYCLES clocks; done high the following clock.
REQ-024 DONE: done=1, busy=0, in1..in3=0, pass=(fail_cnt==0); next clock -> IDLE, done=0.
REQ-025 captured, fail_cnt, first_fail and pass SHALL hold their values in IDLE until the next accepted start.
REQ-026 start while in APPLY or DONE SHALL be ignored and not queued.
REQ-027 abort=1 in APPLY or DONE -> IDLE next clock with no done pulse, pass=0, in1..in3=0; partial captured and fail_cnt retained.
REQ-028 abort and start both high in IDLE: abort wins; no sweep starts.
REQ-029 fail_cnt SHALL saturate at 8 by construction; 4-bit width, no overflow.

Reset
REQ-030 rst_n=0 at a rising edge -> IDLE; all outputs 0; captured=8'h00; row and counter 0.
REQ-031 Reset asserted mid-sweep SHALL abandon the sweep with no done pulse; reset dominates start and abort.

Verification
REQ-032 SETTLE_CYCLES=4, gate modeled as 0x8B, pulse start -> rows 000..111 each held 4 clocks; busy 32 clocks; done pulse; captured=8'h8B, pass=1, fail_cnt=0, first_fail=0.
REQ-033 Gate modeled as constant 1 -> captured=8'hFF, pass=0, fail_cnt=4, first_fail=1.
REQ-034 Gate modeled as 0x8B with row 6 forced to 0 -> captured=8'h89, fail_cnt=1, first_fail=6, pass=0.
REQ-035 abort during row 3 -> IDLE next clock, no done, pass=0, in1..in3=0; then start with correct gate -> pass=1.
REQ-036 start pulsed during APPLY; start and abort asserted together in IDLE -> no extra sweep, no sweep started, respectively.
REQ-037 rst_n=0 during row 5 -> all outputs 0 next clock, no done; SETTLE_CYCLES=1 sweep -> busy exactly 8 clocks.
